sd_spi_responder: RTL and testbench
===================================

# sd_spi_responder

- SD-card-side SPI-mode command responder: the target end of the SD SPI link that our host-side SDIO/SPI bridge drives.
- Oversamples host SCK/CS/MOSI in the local clock domain and decodes 48-bit SD command frames.
- Hands each command to user logic over a valid/ready port, then shifts the user-supplied R1 byte back on MISO.
- Used for SD-card emulation on the FPGA and as a loopback target for bridge verification.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_sck/spi_cs_n/spi_mosi (legal 2..4)
- NCR_BYTES, 1, number of 0xFF filler bytes sent before the R1 byte (legal 1..8)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- spi_sck  in  1  host SPI clock, mode 0 (idle low)
- spi_cs_n  in  1  host chip select, active-low
- spi_mosi  in  1  host data in
- spi_miso  out  1  data to host
- spi_miso_oe  out  1  MISO output enable (synchronized CS asserted)
- cmd_valid  out  1  decoded command available
- cmd_ready  in  1  user accepts command
- cmd_index  out  6  command index
- cmd_arg  out  32  command argument
- rsp_ready  out  1  responder accepts R1 byte
- rsp_valid  in  1  user offers R1 byte
- rsp_data  in  8  R1 byte
- crc_err  out  1  one-clk pulse on CRC7 mismatch
- busy  out  1  high in any state except IDLE

## Operation
- Inputs pass through SYNC_STAGES flops. Rising/falling edges of SCK are detected on the synchronized copy.
- MOSI is sampled on SCK rise. MISO changes on SCK fall.
- Frame layout, MSB first: start 0, transmission bit 1, index[5:0], arg[31:0], crc7[6:0], end bit 1.
- The bit counter (mod 8) is cleared at the start bit. A 48-bit frame therefore leaves byte alignment intact.

States:
- IDLE: MISO=1. A sampled 0 with CS low moves to RX.
- RX: shift 47 more bits.
  - If the transmission bit is 0 or the end bit is 0: frame error, discard, go to IDLE.
  - Otherwise latch index/arg and go to CMD.
- CMD: cmd_valid=1, with index/arg held stable. On cmd_valid&&cmd_ready go to RSP.
- RSP: rsp_ready=1. On rsp_valid&&rsp_ready latch rsp_data and go to TX.
- TX:
  - At the next byte boundary, emit NCR_BYTES×0xFF, then the latched byte MSB first.
  - After bit 0 is shifted out, go to IDLE.
- During CMD and RSP, MISO outputs continuous 1s. The host therefore reads 0xFF while polling.

Boundary rules:
- CS deasserted in IDLE, RX or TX: go to IDLE on the next clk and drop the partial frame or response.
- CS deasserted in CMD or RSP: state is unchanged. The handshake completes. The subsequent TX is skipped, going straight to IDLE.
- CS reasserted mid-TX without an intervening deassert: no effect.
- A start bit in CMD, RSP or TX is ignored. A command issued before the response finishes is not decoded.
- cmd_ready asserted before cmd_valid: no effect.

## Timing
- Reset values:
  - spi_miso=1, spi_miso_oe=0
  - cmd_valid=0, cmd_index=0, cmd_arg=0
  - rsp_ready=0, crc_err=0, busy=0
  - state IDLE
- Requirement: f_clk ≥ 8·f_sck.
- MISO update lands SYNC_STAGES+1 clks after the physical SCK fall.
- cmd_valid rises SYNC_STAGES+1 clks after the SCK rise that samples the end bit.
- Handshakes are single-cycle transfers. rsp_ready drops the clk after acceptance.
- Minimum host-visible turnaround: NCR_BYTES filler bytes, provided the response is given before the first filler byte boundary.

## Configuration
- SDSPI_CRC7_CHECK_EN defined:
  - Serial CRC7 (poly x^7+x^3+1, init 0) is computed over frame bits 47..8.
  - On mismatch: crc_err pulses, no cmd_valid, and TX sends R1=0x08 (COM CRC error) with no user handshake.
- SDSPI_CRC7_CHECK_EN undefined: the CRC field is ignored, no CRC logic is built, and crc_err is tied 0.

## Structure
- Package sd_spi_pkg holds:
  - state enum
  - FRAME_BITS=48
  - CRC7_POLY=7'h09
  - R1_IDLE=8'h01, R1_CRC_ERR=8'h08
- Sub-module sd_crc7: serial CRC7 with clear/enable/bit inputs, instantiated only under SDSPI_CRC7_CHECK_EN.

## Test plan
1. CMD0 frame 40 00 00 00 00 95; user answers 0x01 → cmd_index=0, cmd_arg=0; host reads NCR_BYTES×FF then 01.
2. CMD17 frame 51 00 00 10 00 xx; cmd_ready held low for 100 SCK cycles → cmd_valid stable with arg=0x00001000, host reads only FF, then the response arrives byte-aligned.
3. With SDSPI_CRC7_CHECK_EN, CMD0 frame with CRC byte 0x97 → crc_err 1-clk pulse, no cmd_valid, host reads 08.
4. CS deasserted after 20 frame bits, then a valid CMD8 (48 00 00 01 AA 87) → no command from the partial frame; CMD8 decoded with arg=0x000001AA.
5. Frame with end bit 0 → discarded, busy back to 0, next frame decoded normally.
6. reset_n low mid-TX → all outputs at reset values in the same cycle (asynchronous); after release the first full frame is decoded correctly.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD SPI-mode command responder.
package sd_spi_pkg;

  typedef enum logic [2:0] {StIdle, StRx, StCmd, StRsp, StTx} state_e;

  localparam int unsigned FRAME_BITS = 48;
  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [7:0]  R1_IDLE    = 8'h01;
  localparam logic [7:0]  R1_CRC_ERR = 8'h08;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear restarts from zero and may coincide with the first bit.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d, crc_base;

  always_comb begin
    crc_base = clear_i ? 7'h00 : crc_q;
    crc_d    = crc_base;
    if (en_i) crc_d = crc7_step(crc_base, bit_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 7'h00;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card-side SPI-mode responder: decodes 48-bit command frames and returns an R1 byte.
// Define SDSPI_CRC7_CHECK_EN to check the frame CRC7 and auto-answer R1=0x08 on mismatch.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NCR_BYTES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        rsp_ready,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  output logic        crc_err,
  output logic        busy
);

  localparam int unsigned TxBits = NCR_BYTES * 8 + 8;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '1;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [5:0]  rx_cnt_q;
  logic [45:0] frame_sr_q;  // frame bits 46..1, oldest at the top
  logic [5:0]  cmd_index_q;
  logic [31:0] cmd_arg_q;
  logic        cmd_valid_q, rsp_ready_q, skip_tx_q, tx_active_q, miso_q, oe_q, crc_err_q;
  logic [7:0]  rsp_q;
  logic [6:0]  tx_left_q, tx_next_idx;
  logic        tx_next_bit, crc_bad;

  assign tx_next_idx = tx_left_q - 7'd1;
  assign tx_next_bit = (tx_next_idx < 7'd8) ? rsp_q[tx_next_idx[2:0]] : 1'b1;

`ifdef SDSPI_CRC7_CHECK_EN
  logic [6:0] crc_val;
  logic       crc_en;

  // Covers the start bit (seen in IDLE) and frame bits 46..8.
  assign crc_en = sck_rise && !cs_s &&
                  (((state_q == StIdle) && !mosi_s) || ((state_q == StRx) && (rx_cnt_q < 6'd40)));

  sd_crc7 u_crc7 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (state_q == StIdle),
    .en_i    (crc_en),
    .bit_i   (mosi_s),
    .crc_o   (crc_val)
  );

  assign crc_bad = (crc_val != frame_sr_q[6:0]);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_cnt_q    <= 6'd0;
      frame_sr_q  <= '0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
      cmd_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_q       <= 8'h00;
      skip_tx_q   <= 1'b0;
      tx_active_q <= 1'b0;
      tx_left_q   <= 7'd0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      oe_q      <= !cs_s;
      if (sck_rise && !cs_s) bit_cnt_q <= bit_cnt_q + 3'd1;
      unique case (state_q)
        StIdle: begin
          miso_q    <= 1'b1;
          skip_tx_q <= 1'b0;
          if (sck_rise && !cs_s && !mosi_s) begin
            state_q   <= StRx;
            bit_cnt_q <= 3'd1;
            rx_cnt_q  <= 6'd1;
          end
        end
        StRx: begin
          if (cs_s) begin
            state_q <= StIdle;
          end else if (sck_rise) begin
            frame_sr_q <= {frame_sr_q[44:0], mosi_s};
            rx_cnt_q   <= rx_cnt_q + 6'd1;
            if (rx_cnt_q == 6'(FRAME_BITS - 1)) begin
              if (!frame_sr_q[45] || !mosi_s) begin
                state_q <= StIdle;
              end else if (crc_bad) begin
                crc_err_q   <= 1'b1;
                rsp_q       <= R1_CRC_ERR;
                tx_active_q <= 1'b0;
                state_q     <= StTx;
              end else begin
                cmd_index_q <= frame_sr_q[44:39];
                cmd_arg_q   <= frame_sr_q[38:7];
                cmd_valid_q <= 1'b1;
                state_q     <= StCmd;
              end
            end
          end
        end
        StCmd: begin
          if (cs_s) skip_tx_q <= 1'b1;
          if (cmd_valid_q && cmd_ready) begin
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (cs_s) skip_tx_q <= 1'b1;
          if (rsp_valid && rsp_ready_q) begin
            rsp_ready_q <= 1'b0;
            rsp_q       <= rsp_data;
            tx_active_q <= 1'b0;
            state_q     <= (skip_tx_q || cs_s) ? StIdle : StTx;
          end
        end
        StTx: begin
          if (cs_s) begin
            state_q <= StIdle;
            miso_q  <= 1'b1;
          end else if (sck_fall) begin
            if (!tx_active_q) begin
              // Wait for a byte boundary; the first bit out is always filler.
              if (bit_cnt_q == 3'd0) begin
                tx_active_q <= 1'b1;
                tx_left_q   <= 7'(TxBits - 1);
                miso_q      <= 1'b1;
              end
            end else if (tx_left_q != 7'd0) begin
              tx_left_q <= tx_next_idx;
              miso_q    <= tx_next_bit;
            end
          end else if (sck_rise && tx_active_q && (tx_left_q == 7'd0)) begin
            state_q <= StIdle;
            miso_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_index   = cmd_index_q;
  assign cmd_arg     = cmd_arg_q;
  assign rsp_ready   = rsp_ready_q;
  assign crc_err     = crc_err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: bit-banged SPI host plus a frame-level reference model.
`timescale 1ns/1ps
module tb_sd_spi_responder;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned NcrBytes   = 1;
  localparam int          HalfSck    = 8;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b1;
  logic        spi_miso, spi_miso_oe, cmd_valid, rsp_ready, crc_err, busy;
  logic        cmd_ready = 1'b0, rsp_valid = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int checks = 0, failures = 0;
  int crc_err_cycles = 0, cmd_accepts = 0;
  logic [5:0]  acc_idx_q[$];
  logic [31:0] acc_arg_q[$];
  logic [7:0]  rxb[16];

  always #5 clk = ~clk;

  sd_spi_responder #(
    .SYNC_STAGES (SyncStages),
    .NCR_BYTES   (NcrBytes)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .rsp_ready   (rsp_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .crc_err     (crc_err),
    .busy        (busy)
  );

  // Handshake/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (crc_err === 1'b1) crc_err_cycles++;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        cmd_accepts++;
        acc_idx_q.push_back(cmd_index);
        acc_arg_q.push_back(cmd_arg);
      end
    end
  end

  // Reference model: SD CRC7 over the 40 header bits, MSB first.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, ref_crc7(head), 1'b1};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    spi_mosi = b;
    tick(HalfSck);
    spi_sck = 1'b1;
    r = spi_miso;
    tick(HalfSck);
    spi_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] dummy;
    for (int i = 5; i >= 0; i--) xfer_byte(f[i*8 +: 8], dummy);
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'hFF, b);
      rxb[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(HalfSck);
  endtask

  task automatic cs_high();
    tick(HalfSck);
    spi_cs_n = 1'b1;
    tick(HalfSck);
  endtask

  // Expect one accepted command equal to (idx, arg) since acc0, and NCR x FF then r1 in rxb.
  task automatic expect_cmd_rsp(input string name, input int acc0, input logic [5:0] idx,
                                input logic [31:0] arg, input logic [7:0] r1);
    logic [37:0] got;
    checks++;
    if (cmd_accepts - acc0 != 1 || acc_idx_q.size() == 0) begin
      failures++;
      $display("FAIL %s_accepts got=%0d want=1", name, cmd_accepts - acc0);
    end else begin
      got = {acc_idx_q.pop_front(), acc_arg_q.pop_front()};
      checks++;
      if (got !== {idx, arg}) begin
        failures++;
        $display("FAIL %s_decode got=%h want=%h", name, got, {idx, arg});
      end
    end
    for (int i = 0; i < int'(NcrBytes); i++) begin
      checks++;
      if (rxb[i] !== 8'hFF) begin
        failures++;
        $display("FAIL %s_filler%0d got=%h want=ff", name, i, rxb[i]);
      end
    end
    checks++;
    if (rxb[NcrBytes] !== r1) begin
      failures++;
      $display("FAIL %s_r1 got=%h want=%h", name, rxb[NcrBytes], r1);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({spi_miso, spi_miso_oe, cmd_valid, cmd_index, cmd_arg, rsp_ready, crc_err, busy}
        !== {1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got=%b/%b/%b/%h/%h/%b/%b/%b", spi_miso, spi_miso_oe, cmd_valid,
               cmd_index, cmd_arg, rsp_ready, crc_err, busy);
    end
  endtask

  task automatic test_cmd0();
    int acc0;
    acc_idx_q.delete(); acc_arg_q.delete();
    acc0 = cmd_accepts;
    cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 8'h01;
    cs_low();
    checks++;
    if (spi_miso_oe !== 1'b1) begin
      failures++;
      $display("FAIL cmd0_oe got=%b want=1", spi_miso_oe);
    end
    send_frame(48'h40_00_00_00_00_95);
    read_bytes(NcrBytes + 1);
    expect_cmd_rsp("cmd0", acc0, 6'd0, 32'd0, 8'h01);
    cs_high();
  endtask

  task automatic test_cmd_hold();
    int acc0;
    logic [7:0] r1, b;
    bit found;
    acc_idx_q.delete(); acc_arg_q.delete();
    acc0 = cmd_accepts;
    r1 = 8'($urandom_range(0, 254));
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = r1;
    cs_low();
    send_frame(make_frame(6'd17, 32'h0000_1000));
    for (int i = 0; i < 13; i++) begin
      xfer_byte(8'hFF, b);
      checks++;
      if ({b, cmd_valid, cmd_index, cmd_arg, rsp_ready} !== {8'hFF, 1'b1, 6'd17, 32'h1000, 1'b0}) begin
        failures++;
        $display("FAIL hold_poll%0d got=%h/%b/%0d/%h/%b want=ff/1/17/00001000/0", i, b, cmd_valid,
                 cmd_index, cmd_arg, rsp_ready);
      end
    end
    cmd_ready = 1'b1; rsp_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      xfer_byte(8'hFF, b);
      if (b !== 8'hFF) found = 1'b1;
    end
    checks++;
    if (!found || b !== r1) begin
      failures++;
      $display("FAIL hold_r1 got=%h want=%h", b, r1);
    end
    checks++;
    if (cmd_accepts - acc0 != 1 || rsp_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_handshake got=%0d/%b want=1/0", cmd_accepts - acc0, rsp_ready);
    end
    cs_high();
  endtask

  task automatic test_crc();
    int acc0, crc0;
    acc_idx_q.delete(); acc_arg_q.delete();
    acc0 = cmd_accepts; crc0 = crc_err_cycles;
    cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 8'h01;
    cs_low();
    send_frame(48'h40_00_00_00_00_97);
    read_bytes(NcrBytes + 1);
`ifdef SDSPI_CRC7_CHECK_EN
    checks++;
    if (crc_err_cycles - crc0 != 1 || cmd_accepts != acc0) begin
      failures++;
      $display("FAIL crc_pulse got=%0d/%0d want=1/0", crc_err_cycles - crc0, cmd_accepts - acc0);
    end
    checks++;
    if (rxb[NcrBytes] !== 8'h08 || rxb[0] !== 8'hFF) begin
      failures++;
      $display("FAIL crc_r1 got=%h,%h want=ff,08", rxb[0], rxb[NcrBytes]);
    end
`else
    checks++;
    if (crc_err_cycles != crc0) begin
      failures++;
      $display("FAIL crc_tied got=%0d want=0", crc_err_cycles - crc0);
    end
    expect_cmd_rsp("crc_ignored", acc0, 6'd0, 32'd0, 8'h01);
`endif
    cs_high();
  endtask

  task automatic test_cs_abort();
    int acc0;
    logic [47:0] f;
    logic r;
    acc_idx_q.delete(); acc_arg_q.delete();
    acc0 = cmd_accepts;
    cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 8'h01;
    f = make_frame(6'd17, $urandom);
    cs_low();
    for (int i = 47; i >= 28; i--) xfer_bit(f[i], r);
    cs_high();
    checks++;
    if (busy !== 1'b0 || cmd_accepts != acc0) begin
      failures++;
      $display("FAIL abort_idle got=%b/%0d want=0/0", busy, cmd_accepts - acc0);
    end
    cs_low();
    send_frame(48'h48_00_00_01_AA_87);
    read_bytes(NcrBytes + 1);
    expect_cmd_rsp("cmd8", acc0, 6'd8, 32'h0000_01AA, 8'h01);
    cs_high();
  endtask

  task automatic test_end_bit();
    int acc0;
    logic [5:0] idx;
    logic [31:0] arg;
    logic [7:0] r1;
    acc_idx_q.delete(); acc_arg_q.delete();
    acc0 = cmd_accepts;
    cmd_ready = 1'b1; rsp_valid = 1'b1;
    cs_low();
    send_frame(make_frame(6'd9, 32'h1234_5678) & ~48'h1);
    tick(HalfSck);
    checks++;
    if (busy !== 1'b0 || cmd_accepts != acc0) begin
      failures++;
      $display("FAIL endbit_discard got=%b/%0d want=0/0", busy, cmd_accepts - acc0);
    end
    idx = 6'($urandom); arg = $urandom; r1 = 8'($urandom);
    rsp_data = r1;
    send_frame(make_frame(idx, arg));
    read_bytes(NcrBytes + 1);
    expect_cmd_rsp("endbit_next", acc0, idx, arg, r1);
    cs_high();
  endtask

  task automatic test_back_to_back();
    logic [5:0] idx;
    logic [31:0] arg;
    logic [7:0] r1;
    int acc0;
    cmd_ready = 1'b1; rsp_valid = 1'b1;
    cs_low();
    for (int n = 0; n < 6; n++) begin
      acc_idx_q.delete(); acc_arg_q.delete();
      acc0 = cmd_accepts;
      idx = 6'($urandom); arg = $urandom; r1 = 8'($urandom);
      rsp_data = r1;
      send_frame(make_frame(idx, arg));
      read_bytes(NcrBytes + 1);
      expect_cmd_rsp("b2b", acc0, idx, arg, r1);
    end
    cs_high();
  endtask

  task automatic test_reset_mid_tx();
    logic [5:0] idx;
    logic [31:0] arg;
    logic [7:0] r1;
    logic r;
    int acc0;
    cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 8'h5A;
    cs_low();
    send_frame(make_frame(6'd55, $urandom));
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, r);
    checks++;
    if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin
      failures++;
      $display("FAIL midtx_active got=%b/%b want=1/1", busy, spi_miso_oe);
    end
    #3 reset_n = 1'b0;
    #1 test_reset();
    tick(2);
    spi_cs_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    acc_idx_q.delete(); acc_arg_q.delete();
    acc0 = cmd_accepts;
    idx = 6'($urandom); arg = $urandom; r1 = 8'($urandom);
    rsp_data = r1;
    cs_low();
    send_frame(make_frame(idx, arg));
    read_bytes(NcrBytes + 1);
    expect_cmd_rsp("post_reset", acc0, idx, arg, r1);
    cs_high();
  endtask

  initial begin
    tick(3);
    test_reset();
    reset_n = 1'b1;
    tick(4);
    test_cmd0();
    test_cmd_hold();
    test_crc();
    test_cs_abort();
    test_end_bit();
    test_back_to_back();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
